reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised successor of the single-write register file: NUM_RD read ports and NUM_WR write ports.
- Write-to-read bypass with deterministic multi-writer priority.
- Integrated scoreboard of per-register busy bits (pending-producer tracking) so issue logic can detect RAW hazards against long-latency writebacks.
- Sits between decode/issue (reads and busy queries) and the writeback stage(s) (writes).

Parameters:
- ADDR_WIDTH, _REG_ADDR_WIDTH_ (5): register index width.
- DATA_WIDTH, _REG_DATA_WIDTH_ (32): register data width.
- REG_NUMBER, _REG_NUMBER_ (32): number of architectural registers. Must be ≤ 2**ADDR_WIDTH.
- NUM_RD, 2: read ports, 1..4.
- NUM_WR, 2: write ports, 1..3. Higher index = younger writer = higher priority.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- i_RdAddr  in  NUM_RD*ADDR_WIDTH  read addresses; port p occupies bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- o_RdData  out  NUM_RD*DATA_WIDTH  read data, same packing.
- o_RdBusy  out  NUM_RD  port p's source register has a pending producer.
- i_WrEn  in  NUM_WR  write enables.
- i_WrAddr  in  NUM_WR*ADDR_WIDTH  write addresses.
- i_WrData  in  NUM_WR*DATA_WIDTH  write data.
- i_IssueEn  in  1  an instruction with a destination register issues this cycle.
- i_IssueAddr  in  ADDR_WIDTH  destination register to mark busy.
- i_Flush  in  1  clears all busy bits (pipeline flush).
- o_Busy  out  REG_NUMBER  raw busy vector, for debug and issue logic.

Behaviour:
- Reset (async assert, sync release): all registers = 0, all busy bits = 0. Consequently o_RdData = 0, o_RdBusy = 0 and o_Busy = 0 while reset is held.
- x0: always reads 0. Writes to x0 are ignored. x0 is never busy; an issue to x0 is ignored.
- Read path is purely combinational (0-cycle latency). Port p returns, in order of precedence:
  - 0 if address is 0.
  - Otherwise i_WrData of the highest-index write port w with i_WrEn[w] && i_WrAddr[w] == addr (bypass).
  - Otherwise the stored value.
- Write: on posedge clk, each enabled write port with a nonzero address updates its register.
- Write conflict: when several enabled ports target the same register, the highest-index port's data is stored. Bypass uses the same rule, so the read value always equals the value stored at the edge.
- Addresses ≥ REG_NUMBER: reads return 0, writes are ignored, issues are ignored. No X propagation.
- Scoreboard next state per register r (≠ 0), evaluated at posedge clk:
  - set if i_IssueEn && i_IssueAddr == r;
  - else clear if i_Flush;
  - else clear if any enabled write port targets r;
  - else hold.
- Scoreboard edge cases:
  - Issue and writeback to the same register in one cycle: the bit stays set, because the new producer supersedes the old one.
  - Issue in the flush cycle: that issue's bit is set (post-flush instruction); all others clear.
- o_RdBusy[p] = busy[addr_p] && !(any enabled write port targets addr_p this cycle). The same-cycle writeback is bypassed, so no stall is reported. Forced to 0 for address 0 and for out-of-range addresses.
- One issue per cycle. A single busy bit per register means a second issue to an already-busy register simply keeps it busy. Ordering of multiple outstanding producers is the issuer's responsibility.
- Reset asserted mid-operation: immediate clear of data and scoreboard. Writes and issues in that cycle are lost.

Decomposition:
- Add to light_rv32i_defs.vh: _REG_NUM_RD_ and _REG_NUM_WR_ defaults, alongside the existing _REG_ADDR_WIDTH_, _REG_DATA_WIDTH_ and _REG_NUMBER_.
- Sub-module reg_scoreboard: busy vector, issue/flush/clear logic, and the o_RdBusy qualification. Interface is addresses plus enables only, no data.
- reg_file_sb owns the storage array, the write-priority logic and the bypass muxes, built with generate loops over NUM_RD and NUM_WR.

Test Plan:
- Reset mid-run after writing x5 = 0xDEADBEEF and issuing x5: assert reset → o_RdData = 0 and o_Busy = 0 asynchronously; after release, a read of x5 returns 0.
- Write conflict: WrEn = 2'b11, both ports target x7, port0 data 0x11111111, port1 data 0x22222222 → same-cycle read of x7 returns 0x22222222; the next cycle also reads 0x22222222.
- x0 handling: write x0 = 0xFFFFFFFF on every port and issue x0 → read x0 = 0, o_Busy[0] = 0.
- Scoreboard lifecycle: issue x3 in cycle N → o_Busy[3] = 1 in N+1 and o_RdBusy = 1 for a read of x3. Write x3 = 0xA5 in N+3 → in that cycle o_RdBusy = 0 and o_RdData = 0xA5; in N+4, o_Busy[3] = 0.
- Simultaneous issue and writeback to x9 → the bit remains 1 the next cycle. Flush together with issue of x4, while x2 and x9 are busy → only o_Busy[4] = 1 afterwards.
- Out-of-range access with REG_NUMBER = 16, ADDR_WIDTH = 5: write x20 = 0x1234 → no register changes. A read of x20 returns 0 with o_RdBusy = 0.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// Shared defaults for the multi-port register file
// and its busy-bit scoreboard.
package reg_file_sb_pkg;

   localparam int DEF_ADDR_WIDTH = 5;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_REG_NUMBER = 32;
   localparam int DEF_NUM_RD     = 2;
   localparam int DEF_NUM_WR     = 2;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-producer bits.
// An issue sets a bit; a flush or a writeback clears it.
module reg_scoreboard
   import reg_file_sb_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int REG_NUMBER = DEF_REG_NUMBER,
   parameter int NUM_RD     = DEF_NUM_RD,
   parameter int NUM_WR     = DEF_NUM_WR
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] i_RdAddr,
   input  logic [NUM_WR-1:0]            i_WrEn,
   input  logic [NUM_WR*ADDR_WIDTH-1:0] i_WrAddr,
   input  logic                         i_IssueEn,
   input  logic [ADDR_WIDTH-1:0]        i_IssueAddr,
   input  logic                         i_Flush,
   output logic [NUM_RD-1:0]            o_RdBusy,
   output logic [REG_NUMBER-1:0]        o_Busy
);

   logic [REG_NUMBER-1:0] busy_q;
   logic [REG_NUMBER-1:0] busy_d;
   logic [REG_NUMBER-1:0] wr_hit;
   logic [NUM_RD-1:0]     rd_busy;

   // Mark every register targeted by an enabled write port
   always_comb begin
      wr_hit = '0;
      for (int r = 1; r < REG_NUMBER; r++) begin
         for (int w = 0; w < NUM_WR; w++) begin
            if (i_WrEn[w] &&
                i_WrAddr[w*ADDR_WIDTH +: ADDR_WIDTH] ==
                ADDR_WIDTH'(r)) begin
               wr_hit[r] = 1'b1;
            end
         end
      end
   end

   // Issue beats flush beats writeback; x0 never busy
   always_comb begin
      busy_d    = busy_q;
      busy_d[0] = 1'b0;
      for (int r = 1; r < REG_NUMBER; r++) begin
         if (i_IssueEn && i_IssueAddr == ADDR_WIDTH'(r)) begin
            busy_d[r] = 1'b1;
         end else if (i_Flush) begin
            busy_d[r] = 1'b0;
         end else if (wr_hit[r]) begin
            busy_d[r] = 1'b0;
         end
      end
   end

   // Busy vector register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // A same-cycle writeback is bypassed, so it hides the stall
   always_comb begin
      rd_busy = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         for (int r = 1; r < REG_NUMBER; r++) begin
            if (i_RdAddr[p*ADDR_WIDTH +: ADDR_WIDTH] ==
                ADDR_WIDTH'(r)) begin
               rd_busy[p] = busy_q[r] & ~wr_hit[r];
            end
         end
      end
   end

   assign o_RdBusy = rd_busy;
   assign o_Busy   = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with write-to-read bypass
// and an integrated pending-producer scoreboard.
module reg_file_sb
   import reg_file_sb_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int REG_NUMBER = DEF_REG_NUMBER,
   parameter int NUM_RD     = DEF_NUM_RD,
   parameter int NUM_WR     = DEF_NUM_WR
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] i_RdAddr,
   output logic [NUM_RD*DATA_WIDTH-1:0] o_RdData,
   output logic [NUM_RD-1:0]            o_RdBusy,
   input  logic [NUM_WR-1:0]            i_WrEn,
   input  logic [NUM_WR*ADDR_WIDTH-1:0] i_WrAddr,
   input  logic [NUM_WR*DATA_WIDTH-1:0] i_WrData,
   input  logic                         i_IssueEn,
   input  logic [ADDR_WIDTH-1:0]        i_IssueAddr,
   input  logic                         i_Flush,
   output logic [REG_NUMBER-1:0]        o_Busy
);

   logic [DATA_WIDTH-1:0] regs_q [REG_NUMBER];
   logic [DATA_WIDTH-1:0] regs_d [REG_NUMBER];
   logic [ADDR_WIDTH-1:0] wr_addr [NUM_WR];
   logic [DATA_WIDTH-1:0] wr_data [NUM_WR];

   for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
      assign wr_addr[w] = i_WrAddr[w*ADDR_WIDTH +: ADDR_WIDTH];
      assign wr_data[w] = i_WrData[w*DATA_WIDTH +: DATA_WIDTH];
   end

   // Later write ports overwrite earlier ones: youngest wins
   always_comb begin
      regs_d = regs_q;
      for (int r = 1; r < REG_NUMBER; r++) begin
         for (int w = 0; w < NUM_WR; w++) begin
            if (i_WrEn[w] && wr_addr[w] == ADDR_WIDTH'(r)) begin
               regs_d[r] = wr_data[w];
            end
         end
      end
   end

   // Register storage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;

      assign addr = i_RdAddr[p*ADDR_WIDTH +: ADDR_WIDTH];

      // Stored value, overridden by the youngest matching writer
      always_comb begin
         data = '0;
         for (int r = 1; r < REG_NUMBER; r++) begin
            if (addr == ADDR_WIDTH'(r)) begin
               data = regs_q[r];
               for (int w = 0; w < NUM_WR; w++) begin
                  if (i_WrEn[w] && wr_addr[w] == addr) begin
                     data = wr_data[w];
                  end
               end
            end
         end
      end

      assign o_RdData[p*DATA_WIDTH +: DATA_WIDTH] = data;
   end

   reg_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .REG_NUMBER (REG_NUMBER),
      .NUM_RD     (NUM_RD),
      .NUM_WR     (NUM_WR)
   ) u_sb (
      .clk         (clk),
      .reset       (reset),
      .i_RdAddr    (i_RdAddr),
      .i_WrEn      (i_WrEn),
      .i_WrAddr    (i_WrAddr),
      .i_IssueEn   (i_IssueEn),
      .i_IssueAddr (i_IssueAddr),
      .i_Flush     (i_Flush),
      .o_RdBusy    (o_RdBusy),
      .o_Busy      (o_Busy)
   );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb (16 registers, 2R/2W):
// stimulus queues expectations, a negedge monitor checks them.
module tb_reg_file_sb;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NR = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [2*AW-1:0] rd_addr;
   logic [2*DW-1:0] rd_data;
   logic [1:0]    rd_busy;
   logic [1:0]    wr_en;
   logic [2*AW-1:0] wr_addr;
   logic [2*DW-1:0] wr_data;
   logic          iss_en;
   logic [AW-1:0] iss_addr;
   logic          flush;
   logic [NR-1:0] busy;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } chk_t;

   chk_t q[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   reg_file_sb #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .REG_NUMBER (NR),
      .NUM_RD     (2),
      .NUM_WR     (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .i_RdAddr    (rd_addr),
      .o_RdData    (rd_data),
      .o_RdBusy    (rd_busy),
      .i_WrEn      (wr_en),
      .i_WrAddr    (wr_addr),
      .i_WrData    (wr_data),
      .i_IssueEn   (iss_en),
      .i_IssueAddr (iss_addr),
      .i_Flush     (flush),
      .o_Busy      (busy)
   );

   // Monitor: pop and compare every queued expectation
   always @(negedge clk) begin
      chk_t        c;
      logic [31:0] act;
      while (q.size() > 0) begin
         c = q.pop_front();
         case (c.sel)
            0:       act = rd_data[31:0];
            1:       act = rd_data[63:32];
            2:       act = {30'b0, rd_busy};
            default: act = {16'b0, busy};
         endcase
         total++;
         if (act !== c.exp) begin
            bad++;
            $display("FAIL %s: got %h want %h",
                     c.name, act, c.exp);
         end
      end
   end

   task automatic expect_v(input string n, input int s,
                           input logic [31:0] v);
      chk_t c;
      c.name = n;
      c.sel  = s;
      c.exp  = v;
      q.push_back(c);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      wr_en  = 2'b00;
      iss_en = 1'b0;
      flush  = 1'b0;
   endtask

   task automatic wr(input int w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
      wr_en[w]           = 1'b1;
      wr_addr[w*AW +: AW] = a;
      wr_data[w*DW +: DW] = d;
   endtask

   task automatic issue(input logic [AW-1:0] a);
      iss_en   = 1'b1;
      iss_addr = a;
   endtask

   task automatic rd(input logic [AW-1:0] a0,
                     input logic [AW-1:0] a1);
      rd_addr = {a1, a0};
   endtask

   initial begin
      reset    = 1'b1;
      rd_addr  = '0;
      wr_en    = '0;
      wr_addr  = '0;
      wr_data  = '0;
      iss_en   = 1'b0;
      iss_addr = '0;
      flush    = 1'b0;

      cyc();
      rd(5, 7);
      expect_v("rst_rd0", 0, 32'h0);
      expect_v("rst_busy", 3, 32'h0);
      expect_v("rst_rdbusy", 2, 32'h0);

      cyc();
      reset = 1'b0;
      wr(0, 5, 32'hDEADBEEF);
      expect_v("byp_x5", 0, 32'hDEADBEEF);

      cyc();
      issue(5);
      expect_v("st_x5", 0, 32'hDEADBEEF);
      expect_v("rdbusy_pre", 2, 32'h0);

      cyc();
      expect_v("busy_x5", 3, 32'h20);
      expect_v("rdbusy_x5", 2, 32'h1);

      cyc();
      reset = 1'b1;
      expect_v("mid_rst_rd0", 0, 32'h0);
      expect_v("mid_rst_busy", 3, 32'h0);

      cyc();
      reset = 1'b0;
      expect_v("post_rst_x5", 0, 32'h0);
      expect_v("post_rst_busy", 3, 32'h0);

      cyc();
      wr(0, 7, 32'h11111111);
      wr(1, 7, 32'h22222222);
      expect_v("conf_byp", 1, 32'h22222222);

      cyc();
      expect_v("conf_st", 1, 32'h22222222);

      cyc();
      wr(0, 0, 32'hFFFFFFFF);
      wr(1, 0, 32'hFFFFFFFF);
      issue(0);
      rd(0, 7);
      expect_v("x0_byp", 0, 32'h0);
      expect_v("x0_x7", 1, 32'h22222222);

      cyc();
      expect_v("x0_st", 0, 32'h0);
      expect_v("x0_busy", 3, 32'h0);

      cyc();
      issue(3);
      rd(3, 7);
      expect_v("lc_n_rd", 0, 32'h0);
      expect_v("lc_n_rdbusy", 2, 32'h0);

      cyc();
      expect_v("lc_n1_busy", 3, 32'h8);
      expect_v("lc_n1_rdbusy", 2, 32'h1);

      cyc();
      expect_v("lc_n2_rdbusy", 2, 32'h1);

      cyc();
      wr(1, 3, 32'hA5);
      expect_v("lc_n3_rdbusy", 2, 32'h0);
      expect_v("lc_n3_rd", 0, 32'hA5);

      cyc();
      expect_v("lc_n4_busy", 3, 32'h0);
      expect_v("lc_n4_rd", 0, 32'hA5);

      cyc();
      issue(9);
      wr(0, 9, 32'h99);
      expect_v("iwb_pre", 3, 32'h0);

      cyc();
      issue(2);
      rd(9, 7);
      expect_v("iwb_busy", 3, 32'h200);
      expect_v("iwb_rd", 0, 32'h99);
      expect_v("iwb_rdbusy", 2, 32'h1);

      cyc();
      flush = 1'b1;
      issue(4);
      expect_v("fl_pre", 3, 32'h204);

      cyc();
      expect_v("fl_post", 3, 32'h10);

      cyc();
      wr(0, 20, 32'h1234);
      issue(19);
      rd(20, 4);
      expect_v("oor_rd", 0, 32'h0);
      expect_v("oor_alias", 1, 32'h0);
      expect_v("oor_rdbusy", 2, 32'h2);

      cyc();
      rd(3, 4);
      expect_v("oor_busy", 3, 32'h10);
      expect_v("oor_x4", 1, 32'h0);
      expect_v("oor_x3", 0, 32'hA5);

      cyc();
      wr(0, 6, 32'h66);
      wr(1, 8, 32'h88);
      rd(6, 8);
      expect_v("dual_rd0", 0, 32'h66);
      expect_v("dual_rd1", 1, 32'h88);
      expect_v("dual_rdbusy", 2, 32'h0);

      cyc();
      expect_v("dual_st0", 0, 32'h66);
      expect_v("dual_st1", 1, 32'h88);

      cyc();
      for (int i = 0; i < 5 && q.size() > 0; i++) begin
         @(negedge clk);
      end
      #1;
      if (q.size() > 0) begin
         bad++;
         total++;
         $display("FAIL drain: got %0d left want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
